// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_pkg
// Description : Shared types and constants for the bit deserializer.
//               - deser_state_t       : alignment state (HUNT / LOCKED)
//               - DESER_SYNC_DEFAULT  : default alignment/filler byte
//               - FRAME_CNT_W         : width of the emitted-word counter
// Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } deser_state_t;

    localparam logic [7:0] DESER_SYNC_DEFAULT = 8'hA5;
    localparam int         FRAME_CNT_W        = 8;

endpackage : deser_pkg
`default_nettype wire

// File: rtl/deser_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : deser_out_reg
// Description : One-entry valid/ready holding register for assembled words.
// Ports       : clk       - rising-edge clock
//               rst_l     - asynchronous active-low reset
//               load      - a completed word is offered this cycle
//               din       - the offered word
//               ready     - consumer accepts dout when valid && ready
//               valid     - dout holds an undelivered word
//               dout      - held word (stable while valid && !ready)
//               full_drop - offered word cannot be stored (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module deser_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             full_drop
);

    // The slot is free if it is empty or being drained in this same cycle.
    assign full_drop = load && valid && !ready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load && !full_drop) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule : deser_out_reg
`default_nettype wire

// File: rtl/bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_deserializer
// Description : Hunts for a sync word in a serial bit stream, then packs each
//               following WIDTH bits MSB-first into a parallel word. Sync
//               words seen while locked are filler and are suppressed.
// Ports       : clk        - rising-edge clock
//               rst_l      - asynchronous active-low reset
//               q_in       - serial data bit
//               bit_valid  - q_in is sampled only when high
//               resync     - pulse: return to hunting
//               word_data  - assembled word
//               word_valid - word_data holds an undelivered word
//               word_ready - consumer accept
//               locked     - block is aligned
//               overrun    - pulse: a completed word was dropped
//               frame_cnt  - count of emitted words (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DESER_SYNC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   q_in,
    input  logic                   bit_valid,
    input  logic                   resync,
    output logic [WIDTH-1:0]       word_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   locked,
    output logic                   overrun,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int BCNT_W = $clog2(WIDTH);

    localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(WIDTH);
    localparam logic [BCNT_W-1:0] C_BIT_LAST  = BCNT_W'(WIDTH - 1);

    deser_state_t              r_state;
    // Only the low WIDTH-1 bits of the shift register are ever observed: the
    // post-shift word is {r_hist, q_in}, so the oldest bit is never needed.
    logic [WIDTH-2:0]          r_hist;
    logic [FILL_W-1:0]         r_fill;
    logic [BCNT_W-1:0]         r_bitcnt;
    logic                      r_overrun;
    logic [FRAME_CNT_W-1:0]    r_frame_cnt;

    logic [WIDTH-1:0]          w_shift;
    logic [FILL_W-1:0]         w_fill_next;
    logic                      w_match;
    logic                      w_complete;
    logic                      w_emit;
    logic                      w_drop;

    assign w_shift     = {r_hist, q_in};
    assign w_fill_next = (r_fill == C_FILL_FULL) ? C_FILL_FULL : r_fill + FILL_W'(1);

    // resync overrides both alignment and word completion in the same cycle.
    assign w_match    = (r_state == HUNT) && bit_valid && !resync &&
                        (w_shift == SYNC) && (w_fill_next == C_FILL_FULL);
    assign w_complete = (r_state == LOCKED) && bit_valid && !resync &&
                        (r_bitcnt == C_BIT_LAST);
    assign w_emit     = w_complete && (w_shift != SYNC);

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_l     (rst_l),
        .load      (w_emit),
        .din       (w_shift),
        .ready     (word_ready),
        .valid     (word_valid),
        .dout      (word_data),
        .full_drop (w_drop)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= HUNT;
            r_hist      <= '0;
            r_fill      <= '0;
            r_bitcnt    <= '0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_overrun <= w_drop;
            if (w_emit && !w_drop) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end

            if (bit_valid) begin
                r_hist <= w_shift[WIDTH-2:0];
            end

            if (resync) begin
                r_state  <= HUNT;
                r_fill   <= '0;
                r_bitcnt <= '0;
            end else if (bit_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_state  <= LOCKED;
                            r_bitcnt <= '0;
                            r_fill   <= '0;
                        end else begin
                            r_fill <= w_fill_next;
                        end
                    end
                    LOCKED: begin
                        r_bitcnt <= (r_bitcnt == C_BIT_LAST) ? '0 : r_bitcnt + BCNT_W'(1);
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign locked    = (r_state == LOCKED);
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule : bit_deserializer
`default_nettype wire

// File: tb/tb_bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_deserializer
// Description : Self-checking bench for bit_deserializer (WIDTH=8, SYNC=A5).
//               Directed scenarios followed by randomized byte streams, all
//               compared each cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_deserializer;

    localparam int         W  = 8;
    localparam logic [7:0] SY = 8'hA5;

    logic       clk        = 1'b0;
    logic       rst_l      = 1'b0;
    logic       q_in       = 1'b0;
    logic       bit_valid  = 1'b0;
    logic       resync     = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_data;
    logic       word_valid;
    logic       locked;
    logic       overrun;
    logic [7:0] frame_cnt;

    bit_deserializer #(
        .WIDTH (W),
        .SYNC  (SY)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .q_in       (q_in),
        .bit_valid  (bit_valid),
        .resync     (resync),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last 8 received bits as an integer, count of bits seen
    // while hunting, count of bits since lock, and the output slot contents.
    int m_hist;
    int m_fill;
    bit m_locked;
    int m_since;
    bit m_valid;
    int m_data;
    bit m_ovr;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = 0; m_fill = 0; m_locked = 0; m_since = 0;
        m_valid = 0; m_data = 0; m_ovr = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic q, input logic bv, input logic rs, input logic rdy);
        bit nv;
        nv    = m_valid && !rdy;
        m_ovr = 0;
        if (bv) m_hist = ((m_hist << 1) | int'(q)) & 255;
        if (rs) begin
            m_locked = 0; m_fill = 0; m_since = 0;
        end else if (bv) begin
            if (!m_locked) begin
                m_fill = (m_fill < W) ? m_fill + 1 : W;
                if (m_fill >= W && m_hist == int'(SY)) begin
                    m_locked = 1;
                    m_since  = 0;
                end
            end else begin
                m_since++;
                if (m_since % W == 0 && m_hist != int'(SY)) begin
                    if (!m_valid || rdy) begin
                        m_data = m_hist;
                        nv     = 1;
                        m_cnt  = (m_cnt + 1) % 256;
                    end else begin
                        m_ovr = 1;
                    end
                end
            end
        end
        m_valid = nv;
    endtask

    task automatic compare_all();
        check("word_data",  32'(word_data),  32'(m_data));
        check("word_valid", 32'(word_valid), 32'(m_valid));
        check("locked",     32'(locked),     32'(m_locked));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
    endtask

    task automatic step(input logic q, input logic bv, input logic rs, input logic rdy);
        q_in = q; bit_valid = bv; resync = rs; word_ready = rdy;
        @(posedge clk);
        model_edge(q, bv, rs, rdy);
        #1;
        compare_all();
    endtask

    // Sends one byte MSB-first; with gaps, an idle cycle carrying a random
    // q_in precedes every valid bit.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input logic rdy);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) step(1'($urandom), 1'b0, 1'b0, rdy);
            step(b[i], 1'b1, 1'b0, rdy);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] pat;

        // Reset state
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #3;
        compare_all();
        rst_l = 1'b1;

        // Basic lock and emit
        send_byte(SY, 1'b0, 1'b1);
        check("basic_locked", 32'(locked), 32'd1);
        send_byte(8'h3C, 1'b0, 1'b1);
        check("basic_data", 32'(word_data), 32'h3C);
        check("basic_cnt",  32'(frame_cnt), 32'd1);

        // False alignment
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pat = 8'hA0;
        for (int i = 7; i >= 4; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
        check("false_nolock", 32'(locked), 32'd0);
        send_byte(SY, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        check("false_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        check("bp_data", 32'(word_data), 32'h3C);
        check("bp_ovr",  32'(overrun),   32'd1);
        check("bp_cnt",  32'(frame_cnt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Filler and gaps
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(SY, 1'b1, 1'b1);
        send_byte(SY, 1'b1, 1'b1);
        send_byte(SY, 1'b1, 1'b1);
        send_byte(8'h11, 1'b1, 1'b1);
        check("fill_data", 32'(word_data), 32'h11);
        check("fill_cnt",  32'(frame_cnt), 32'd4);

        // resync on the last bit of a word
        pat = 8'h3C;
        for (int i = 7; i >= 1; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
        step(pat[0], 1'b1, 1'b1, 1'b1);
        check("rs_unlock", 32'(locked), 32'd0);
        send_byte(8'h3C, 1'b0, 1'b1);
        check("rs_stay_hunt", 32'(locked), 32'd0);
        send_byte(SY, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);

        // Reset mid-word (asynchronous)
        for (int i = 7; i >= 4; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
        bit_valid = 1'b0;
        #2 rst_l = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_l = 1'b1;
        for (int i = 3; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
        send_byte(SY, 1'b0, 1'b1);
        send_byte(8'hC3, 1'b0, 1'b1);

        // Randomized byte streams with gaps, backpressure and rare resyncs
        for (int n = 0; n < 400; n++) begin
            b = ($urandom_range(0, 2) == 0) ? SY : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
                step(b[i], 1'b1, 1'($urandom_range(0, 60) == 0),
                     1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bit_deserializer
`default_nettype wire
